// File: rtl/serial_bit_source.sv
// Parallel-to-serial bit source feeding the serial sequence detectors, MSB first.
// Optional even-parity trailer bit when SERIAL_BIT_SOURCE_PARITY_EN is defined.
module serial_bit_source #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             stall,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);

`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(NBITS + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NBITS);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [GW-1:0]    r_gcnt;
    logic             r_w;
    logic             r_wv;
    logic             r_busy;
    logic             r_done;
    logic             r_ready;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    localparam logic [CW-1:0] C_PAR = CW'(WIDTH);
    logic             r_par;
`endif

    // r_cnt counts bits already presented on w; a bit is consumed by an unstalled edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_w     <= 1'b0;
            r_wv    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_valid) begin
                        r_state <= S_SHIFT;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
                        r_par   <= ^load_data;
`endif
                        if (!stall) begin
                            r_w     <= load_data[WIDTH-1];
                            r_wv    <= 1'b1;
                            r_shift <= {load_data[WIDTH-2:0], 1'b0};
                            r_cnt   <= CW'(1);
                        end else begin
                            r_shift <= load_data;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_SHIFT: begin
                    if (!stall) begin
                        if (r_cnt == C_LAST) begin
                            r_w    <= 1'b0;
                            r_wv   <= 1'b0;
                            r_done <= 1'b1;
                            if (GAP_CYCLES == 0) begin
                                r_state <= S_IDLE;
                                r_ready <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_GAP;
                                r_gcnt  <= '0;
                            end
                        end else begin
                            r_wv  <= 1'b1;
                            r_cnt <= r_cnt + CW'(1);
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
                            if (r_cnt == C_PAR) begin
                                r_w <= r_par;
                            end else begin
                                r_w     <= r_shift[WIDTH-1];
                                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                            end
`else
                            r_w     <= r_shift[WIDTH-1];
                            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
`endif
                        end
                    end
                end
                S_GAP: begin
                    if (r_gcnt == G_LAST) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gcnt <= r_gcnt + GW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_w     <= 1'b0;
                    r_wv    <= 1'b0;
                end
            endcase
        end
    end

    assign w          = r_w;
    assign w_valid    = r_wv;
    assign busy       = r_busy;
    assign done       = r_done;
    assign load_ready = r_ready;

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model (GAP 0 and GAP 1 instances).
module tb_serial_bit_source;
    localparam int W = 8;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         lv = 1'b0;
    logic         stall = 1'b0;
    logic [W-1:0] data = '0;
    logic [1:0]   ready, w, wv, busy, done;

    serial_bit_source #(.WIDTH(W), .GAP_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .load_valid(lv), .load_data(data),
        .load_ready(ready[0]), .stall(stall), .w(w[0]), .w_valid(wv[0]),
        .busy(busy[0]), .done(done[0])
    );

    serial_bit_source #(.WIDTH(W), .GAP_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .load_valid(lv), .load_data(data),
        .load_ready(ready[1]), .stall(stall), .w(w[1]), .w_valid(wv[1]),
        .busy(busy[1]), .done(done[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: instance k has GAP_CYCLES = k
    int           m_mode[2];
    int           m_pos[2];
    int           m_idle_at[2];
    logic [W-1:0] m_word[2];
    logic         m_w[2], m_wv[2], m_done[2];

    typedef struct {
        logic         lv;
        logic [W-1:0] d;
        logic         st;
        logic [4:0]   exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic wbit(logic [W-1:0] d, int i);
        if (i < W) return d[W-1-i];
        return ^d;
    endfunction

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [4:0] outs(int k);
        return {ready[k], busy[k], done[k], wv[k], w[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_pos[k]  = 0;
            m_w[k]    = 1'b0;
            m_wv[k]   = 1'b0;
            m_done[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            case (m_mode[k])
                0: if (lv) begin
                    m_word[k] = data;
                    m_mode[k] = 1;
                    if (!stall) begin
                        m_w[k] = wbit(data, 0); m_wv[k] = 1'b1; m_pos[k] = 1;
                    end else begin
                        m_w[k] = 1'b0; m_wv[k] = 1'b0; m_pos[k] = 0;
                    end
                end
                1: if (!stall) begin
                    if (m_pos[k] == NB) begin
                        m_done[k] = 1'b1; m_w[k] = 1'b0; m_wv[k] = 1'b0;
                        if (k == 0) m_mode[k] = 0;
                        else begin
                            m_mode[k] = 2;
                            m_idle_at[k] = cyc + k + 1;
                        end
                    end else begin
                        m_w[k] = wbit(m_word[k], m_pos[k]);
                        m_wv[k] = 1'b1;
                        m_pos[k]++;
                    end
                end
                default: if (cyc >= m_idle_at[k]) m_mode[k] = 0;
            endcase
        end
    endtask

    task automatic cmp_model();
        for (int k = 0; k < 2; k++)
            check($sformatf("model_u%0d_cyc%0d", k, cyc), outs(k),
                  {m_mode[k] == 0, m_mode[k] != 0, m_done[k], m_wv[k], m_w[k]});
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else model_edge();
        #1;
        cmp_model();
    endtask

    task automatic idle(int n);
        lv = 1'b0; stall = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        logic [16:0] b2b;
        logic [10:0] f0s;
        int ndone;

        model_reset();
        step();
        step();
        check("reset_u1", outs(1), 5'b10000);
        check("reset_u0", outs(0), 5'b10000);
        rst = 1'b0;
        step();

        // 8'hA5 on the GAP=1 instance: {ready,busy,done,w_valid,w}
        tbl.push_back('{1'b1, 8'hA5, 1'b0, 5'b01011});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 5'b01010});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 5'b01011});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 5'b01010});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 5'b01010});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 5'b01011});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 5'b01010});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 5'b01011});
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
        tbl.push_back('{1'b0, 8'h00, 1'b0, 5'b01010});
`endif
        tbl.push_back('{1'b0, 8'h00, 1'b0, 5'b01100});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 5'b01000});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 5'b10000});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 5'b10000});
        for (int i = 0; i < tbl.size(); i++) begin
            lv = tbl[i].lv; data = tbl[i].d; stall = tbl[i].st;
            step();
            check($sformatf("vec%0d", i), outs(1), tbl[i].exp);
        end

        // 8'hF0 with 3 stall cycles after the third bit
        f0s = 11'b111_1111_0000;
        for (int i = 1; i <= NB + 4; i++) begin
            lv = (i == 1); data = 8'hF0; stall = (i >= 4 && i <= 6);
            step();
            if (i <= NB + 3) begin
                if (i <= 11)
                    check($sformatf("f0_bit%0d", i), {wv[1], w[1]},
                          {1'b1, f0s[11-i]});
            end else begin
                check("f0_done_late", done[1], 1'b1);
            end
        end
        idle(3);

`ifndef SERIAL_BIT_SOURCE_PARITY_EN
        // back-to-back on the GAP=0 instance
        b2b = 17'b1000_0001_0_0111_1110;
        ndone = 0;
        for (int i = 1; i <= 19; i++) begin
            lv = (i <= 10); data = (i == 1) ? 8'h81 : 8'h7E; stall = 1'b0;
            step();
            if (done[0]) ndone++;
            if (i == 9)
                check("b2b_gap", {done[0], wv[0], w[0]}, 3'b100);
            else if (i <= 17)
                check($sformatf("b2b_bit%0d", i), {wv[0], w[0]},
                      {1'b1, b2b[17-i]});
        end
        check("b2b_two_dones", ndone, 2);
        idle(3);
`endif

        // async reset mid-word after the 4th bit of 8'hCC
        lv = 1'b1; data = 8'hCC;
        step();
        lv = 1'b0;
        repeat (3) step();
        check("cc_bit4", {wv[1], w[1]}, 2'b10);
        #3 rst = 1'b1;
        #1;
        check("async_rst_u1", outs(1), 5'b10000);
        check("async_rst_u0", outs(0), 5'b10000);
        model_reset();
        #2 rst = 1'b0;
        ndone = 0;
        repeat (3) begin
            step();
            if (done[1]) ndone++;
        end
        check("no_done_after_rst", ndone, 0);
        for (int i = 1; i <= NB + 1; i++) begin
            lv = (i == 1); data = 8'h33;
            step();
            if (i <= W)
                check($sformatf("h33_bit%0d", i), {wv[1], w[1]},
                      {1'b1, wbit(8'h33, i - 1)});
            else if (i == NB + 1)
                check("h33_done", done[1], 1'b1);
        end
        idle(3);

        // load coinciding with reset: word dropped
        rst = 1'b1; lv = 1'b1; data = 8'hFF;
        step();
        rst = 1'b0; lv = 1'b0;
        step();
        check("load_rst_dropped", outs(1), 5'b10000);

`ifdef SERIAL_BIT_SOURCE_PARITY_EN
        for (int t = 0; t < 2; t++) begin
            for (int i = 1; i <= 10; i++) begin
                lv = (i == 1); data = (t == 0) ? 8'hA5 : 8'h07;
                step();
                if (i == 9)
                    check($sformatf("par%0d_bit9", t), {wv[1], w[1]},
                          {1'b1, t == 1});
                if (i == 10)
                    check($sformatf("par%0d_done", t), done[1], 1'b1);
            end
            idle(3);
        end
`endif

        // randomized traffic, model checks every cycle
        for (int n = 0; n < 3000; n++) begin
            lv    = ($urandom_range(0, 1) == 1);
            data  = W'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Parallel-to-serial stage directly upstream of the group's serial sequence-detector FSMs (clk/rst/w → z).
- Accepts a WIDTH-bit word through a valid/ready handshake and drives it one bit per clock onto `w`, MSB first.
- Inserts a programmable idle gap between words.
- Lets a bench or a higher level drive the detector from stored patterns instead of hand-timed bit toggling.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- GAP_CYCLES, 1, cycles `w` is held 0 after each word before the next load is accepted; 0 is legal (no gap).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load_valid  input  1  upstream offers `load_data`
- load_data  input  WIDTH  word to serialize
- load_ready  output  1  block can accept a word this cycle
- stall  input  1  freeze shifting; holds `w` and the bit counter
- w  output  1  serial bit to the detector
- w_valid  output  1  `w` carries a payload bit this cycle
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse after the last bit of a word

Behaviour:
- Reset (async, any time, including mid-word):
  - state=IDLE; shift register, bit counter and gap counter cleared.
  - Outputs: w=0, w_valid=0, busy=0, done=0, load_ready=1.
- States: IDLE, SHIFT, GAP. All outputs are registered.
- IDLE:
  - load_ready=1, w=0, w_valid=0.
  - Acceptance occurs on a posedge with load_valid=1.
  - At acceptance: capture load_data, set bit counter=0, go to SHIFT.
  - The MSB appears on `w` with w_valid=1 immediately after that edge (zero extra latency).
- SHIFT:
  - load_ready=0. load_valid is ignored; the upstream must hold it until it sees load_ready=1.
  - Each posedge with stall=0 presents the next bit (MSB→LSB) and increments the counter.
  - With stall=1: w, w_valid and the counter hold; no bit is consumed.
  - Each payload bit occupies exactly one unstalled cycle.
  - On the edge after the last payload bit is presented and unstalled:
    - done=1 for exactly one cycle, w=0, w_valid=0.
    - Go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP:
  - w=0, w_valid=0, load_ready=0.
  - The gap counter counts GAP_CYCLES edges, then the state returns to IDLE.
  - stall does not affect GAP.
- Back-to-back words: with GAP_CYCLES=0 and load_valid held high, the next word's MSB follows the done cycle by one cycle. Minimum spacing between words is 1 idle cycle (the done/IDLE cycle).
- stall asserted while in IDLE: a load is still accepted, but the MSB is held until stall drops.
- Load and reset in the same cycle: reset wins and the word is dropped.
- busy=1 in SHIFT and GAP.
- done never overlaps w_valid=1.

Optional Feature:
- Macro: SERIAL_BIT_SOURCE_PARITY_EN.
- Defined:
  - After the LSB, one extra bit is sent with w_valid=1: the even parity of the word (XOR of all bits).
  - The word therefore occupies WIDTH+1 unstalled cycles, and done follows the parity bit.
  - The parity bit obeys stall like a payload bit.
- Undefined:
  - Exactly WIDTH bits per word; no parity logic is synthesized.

Test Plan:
- WIDTH=8, GAP_CYCLES=1, load 8'hA5 with stall=0 → w = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with w_valid=1; done=1 on cycle 9; w=0 for 1 gap cycle; load_ready=1 on cycle 11.
- Load 8'hF0, assert stall for 3 cycles after the third bit → w holds 1 for those 3 extra cycles; remaining bits 1,0,0,0,0; done arrives 3 cycles later than in the unstalled run.
- GAP_CYCLES=0, load_valid held high with 8'h81 then 8'h7E → stream 1,0,0,0,0,0,0,1, [done cycle, w=0], 0,1,1,1,1,1,1,0; exactly two done pulses.
- Assert rst for 1 cycle asynchronously (between edges) mid-word after the 4th bit of 8'hCC → w=0, w_valid=0, busy=0, load_ready=1 immediately; no done pulse; the next load of 8'h33 serializes cleanly.
- With SERIAL_BIT_SOURCE_PARITY_EN: 8'hA5 → 9th bit 0; 8'h07 → 9th bit 1; done on cycle 10.
- End-to-end: chain into the group's sequence detector and load the pattern 8'b1010_1101 → detector `z` matches a golden reference model cycle-for-cycle; no detector activity during gap cycles.
